meter_time_keeper: RTL and testbench
====================================

Name: meter_time_keeper

Overview:
Upstream stage of the cost converter. It holds the parking session's paid/elapsed seconds count and drives the converter's 12-bit sec_count input. Coin/add pulses from the debounced button stage load time into the count. A 1 Hz tick derived from the system clock decrements it. A small FSM tracks session state and drives a blink flag for the display stage.

Parameters:
TICK_DIV, 100000000, clock cycles per 1 s tick (bench uses 4)
LOW_THRESH, 180, count at or below which a running session is "low time"
MAX_SEC, 4095, saturation ceiling for the count (must be at most 4095)

Ports:
clk  input  1  system clock; sole clock of the block
rst  input  1  synchronous, active-high reset
add_pulse  input  4  one-cycle add requests: bit0 +60 s, bit1 +120 s, bit2 +180 s, bit3 +300 s
clr_pulse  input  1  one-cycle session clear
sec_count  output 12  current seconds count, feeds cost converter
state  output 2  00 EMPTY, 01 RUNNING, 10 EXPIRED
low_time  output 1  high while RUNNING and sec_count <= LOW_THRESH
blink  output 1  display blink phase
tick  output 1  one-cycle 1 Hz strobe (for display/debug)

Behaviour:
- Reset (rst high at a clk edge): sec_count=0, state=EMPTY, blink=0, low_time=0, tick=0, prescaler=0. Reset wins over every other input in the same cycle.
- Prescaler: free-running counter 0..TICK_DIV-1. tick is asserted for exactly the cycle in which the prescaler equals TICK_DIV-1; the prescaler then wraps to 0. The prescaler is not affected by add_pulse or clr_pulse. tick is a registered output.
- Add decode: if more than one add_pulse bit is high in a cycle, only the lowest-index set bit is honoured. add_val is 60, 120, 180 or 300; it is 0 if no bit is set.
- Decrement: dec = 1 when tick is high and sec_count != 0, else 0.
- Count update (no clear): sec_count_next = min(sec_count + add_val - dec, MAX_SEC).
  - Compute with at least 13-bit intermediates.
  - An add and a tick in the same cycle both take effect.
  - The count never wraps below 0 or above MAX_SEC.
- clr_pulse (no rst): sec_count -> 0, state -> EMPTY, blink -> 0. clr_pulse overrides any add_pulse in the same cycle.
- FSM transitions, evaluated on the next-count value:
  - EMPTY: add with result > 0 -> RUNNING; otherwise stay.
  - RUNNING: next count == 0 caused by a decrement -> EXPIRED; otherwise stay.
  - EXPIRED: add with result > 0 -> RUNNING; clr -> EMPTY; otherwise stay.
  - Illegal encoding 11 -> EMPTY on the next clock.
- blink:
  - Toggles on each tick while in EXPIRED, or while in RUNNING with low_time high.
  - Forced to 0 in EMPTY and in RUNNING when not low_time.
  - Registered; updates in the same cycle as the count.
- low_time: combinational from the registered state and sec_count.
- Latency: an add_pulse at edge N is visible on sec_count after edge N (one cycle). No handshake; pulses are never queued or lost except as the documented lowest-index priority.

Test Plan:
1. TICK_DIV=4. Reset, then add_pulse=0001 one cycle -> sec_count=60, state=01. After 4 clocks: tick once, sec_count=59. low_time=1 (60 <= 180).
2. Saturation: from 4000, pulse bit3 -> sec_count=4095, not 4300-4096. A further bit0 pulse -> stays 4095.
3. Simultaneous events: add_pulse=0110 coincident with tick at count 10 -> sec_count=10+120-1=129 (bit1 honoured). clr_pulse with add_pulse=1000 -> sec_count=0, state=00.
4. Expiry: count 2, let 2 ticks elapse -> sec_count=0, state=10 on the second tick. blink toggles on each later tick. Pulse bit0 -> 60, state=01, blink=1/0 per low_time rule.
5. Reset mid-session: count 250 RUNNING, rst high with add_pulse=0001 -> sec_count=0, state=00, blink=0, prescaler restarts (first tick 4 clocks after rst deasserts).
6. EMPTY hold: ticks with count 0 in EMPTY -> sec_count stays 0, state stays 00, blink stays 0, never enters EXPIRED.

Source files
------------

// File: rtl/meter_time_keeper.sv
// Parking-meter session timekeeper: holds the paid seconds count, decrements it
// once per second, and tracks EMPTY/RUNNING/EXPIRED plus a display blink phase.
module meter_time_keeper #(
    parameter int TICK_DIV   = 100000000,
    parameter int LOW_THRESH = 180,
    parameter int MAX_SEC    = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  add_pulse,
    input  logic        clr_pulse,
    output logic [11:0] sec_count,
    output logic [1:0]  state,
    output logic        low_time,
    output logic        blink,
    output logic        tick
);

    localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [11:0] LOW_C   = 12'(LOW_THRESH);
    localparam logic [12:0] MAX_C   = 13'(MAX_SEC);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_RUNNING = 2'b01,
        ST_EXPIRED = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [11:0]   sec_count_q, sec_count_d;
    state_t        state_q, state_d;
    logic          blink_q, blink_d;

    logic [12:0]   add_val;
    logic          dec;
    logic [12:0]   sum;
    logic          low_time_c;

    // tick_q is high exactly while presc_q sits at its terminal value
    always_comb begin
        presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_d == PRESC_TOP);
    end

    always_comb begin
        add_val = 13'd0;
        if (add_pulse[0])      add_val = 13'd60;
        else if (add_pulse[1]) add_val = 13'd120;
        else if (add_pulse[2]) add_val = 13'd180;
        else if (add_pulse[3]) add_val = 13'd300;
    end

    assign low_time_c = (state_q == ST_RUNNING) && (sec_count_q <= LOW_C);

    always_comb begin
        dec         = tick_q && (sec_count_q != 12'd0);
        sum         = {1'b0, sec_count_q} + add_val - {12'd0, dec};
        sec_count_d = (sum > MAX_C) ? MAX_C[11:0] : sum[11:0];
        if (clr_pulse) begin
            sec_count_d = 12'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_pulse) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if ((add_val != 13'd0) && (sec_count_d != 12'd0)) state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (dec && (sec_count_d == 12'd0)) state_d = ST_EXPIRED;
                end
                ST_EXPIRED: begin
                    if ((add_val != 13'd0) && (sec_count_d != 12'd0)) state_d = ST_RUNNING;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Blink is forced low where the display should be steady, otherwise it
    // toggles on ticks seen while the session is expired or running low.
    always_comb begin
        blink_d = blink_q;
        if ((state_d == ST_EMPTY) || ((state_d == ST_RUNNING) && (sec_count_d > LOW_C))) begin
            blink_d = 1'b0;
        end else if (tick_q && ((state_q == ST_EXPIRED) || low_time_c)) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            sec_count_q <= 12'd0;
            state_q     <= ST_EMPTY;
            blink_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            sec_count_q <= sec_count_d;
            state_q     <= state_d;
            blink_q     <= blink_d;
        end
    end

    assign sec_count = sec_count_q;
    assign state     = state_q;
    assign low_time  = low_time_c;
    assign blink     = blink_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_meter_time_keeper.sv
// Directed bench for meter_time_keeper with TICK_DIV=4; expected values are hand-derived.
module tb_meter_time_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  add_pulse;
    logic        clr_pulse;
    logic [11:0] sec_count;
    logic [1:0]  state;
    logic        low_time;
    logic        blink;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    meter_time_keeper #(
        .TICK_DIV(4),
        .LOW_THRESH(180),
        .MAX_SEC(4095)
    ) dut (
        .clk(clk),
        .rst(rst),
        .add_pulse(add_pulse),
        .clr_pulse(clr_pulse),
        .sec_count(sec_count),
        .state(state),
        .low_time(low_time),
        .blink(blink),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; phase mirrors the expected prescaler value after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) phase = 0;
        else     phase = (phase + 1) % 4;
        check("tick_phase", {31'd0, tick}, {31'd0, (phase == 3)});
    endtask

    task automatic pulse(input logic [3:0] a, input logic c);
        add_pulse = a;
        clr_pulse = c;
        step();
        add_pulse = 4'd0;
        clr_pulse = 1'b0;
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < 4 && phase != p; i++) step();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            run_to_phase(3);
            step();
        end
    endtask

    task automatic show(input string what);
        $display("%s: sec_count=%0d state=%0d low_time=%0b blink=%0b tick=%0b",
                 what, sec_count, state, low_time, blink, tick);
    endtask

    initial begin
        rst       = 1'b1;
        add_pulse = 4'd0;
        clr_pulse = 1'b0;
        step();
        step();
        rst = 1'b0;
        show("reset");
        check("rst_count", {20'd0, sec_count}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_blink", {31'd0, blink}, 32'd0);
        check("rst_low",   {31'd0, low_time}, 32'd0);

        // 1: first add and first decrement
        pulse(4'b0001, 1'b0);
        show("add60");
        check("add60_count", {20'd0, sec_count}, 32'd60);
        check("add60_state", {30'd0, state}, 32'd1);
        check("add60_low",   {31'd0, low_time}, 32'd1);
        run_to_phase(3);
        check("pre_tick_count", {20'd0, sec_count}, 32'd60);
        step();
        show("tick1");
        check("tick1_count", {20'd0, sec_count}, 32'd59);
        check("tick1_blink", {31'd0, blink}, 32'd1);

        // 2: saturation
        pulse(4'b0000, 1'b1);
        check("clr_count", {20'd0, sec_count}, 32'd0);
        check("clr_blink", {31'd0, blink}, 32'd0);
        for (int i = 0; i < 14; i++) pulse(4'b1000, 1'b0);
        show("saturate");
        check("sat_count", {20'd0, sec_count}, 32'd4095);
        check("sat_blink", {31'd0, blink}, 32'd0);
        pulse(4'b0001, 1'b0);
        show("sat_hold");
        check("sat_hold_count", {20'd0, sec_count}, 32'd4095);

        // 3: priority decode coincident with a tick, then clear beats add
        pulse(4'b0000, 1'b1);
        run_to_phase(0);
        pulse(4'b0001, 1'b0);
        run_ticks(50);
        check("run10_count", {20'd0, sec_count}, 32'd10);
        run_to_phase(3);
        pulse(4'b0110, 1'b0);
        show("add_tick");
        check("add_tick_count", {20'd0, sec_count}, 32'd129);
        check("add_tick_state", {30'd0, state}, 32'd1);
        pulse(4'b1000, 1'b1);
        show("clr_add");
        check("clr_add_count", {20'd0, sec_count}, 32'd0);
        check("clr_add_state", {30'd0, state}, 32'd0);

        // 4: expiry and blink
        run_to_phase(0);
        pulse(4'b0001, 1'b0);
        run_ticks(58);
        check("cnt2_count", {20'd0, sec_count}, 32'd2);
        check("cnt2_blink", {31'd0, blink}, 32'd0);
        run_ticks(1);
        check("cnt1_count", {20'd0, sec_count}, 32'd1);
        check("cnt1_state", {30'd0, state}, 32'd1);
        check("cnt1_blink", {31'd0, blink}, 32'd1);
        run_ticks(1);
        show("expired");
        check("exp_count", {20'd0, sec_count}, 32'd0);
        check("exp_state", {30'd0, state}, 32'd2);
        check("exp_blink", {31'd0, blink}, 32'd0);
        check("exp_low",   {31'd0, low_time}, 32'd0);
        run_ticks(1);
        check("exp_blink_t1", {31'd0, blink}, 32'd1);
        check("exp_hold_cnt", {20'd0, sec_count}, 32'd0);
        run_ticks(1);
        check("exp_blink_t2", {31'd0, blink}, 32'd0);
        pulse(4'b0001, 1'b0);
        show("revive");
        check("revive_count", {20'd0, sec_count}, 32'd60);
        check("revive_state", {30'd0, state}, 32'd1);
        check("revive_blink", {31'd0, blink}, 32'd0);
        check("revive_low",   {31'd0, low_time}, 32'd1);
        run_ticks(1);
        check("revive_tick_count", {20'd0, sec_count}, 32'd59);
        check("revive_tick_blink", {31'd0, blink}, 32'd1);

        // 5: reset mid-session beats a coincident add
        pulse(4'b0000, 1'b1);
        run_to_phase(0);
        pulse(4'b1000, 1'b0);
        run_ticks(50);
        show("run250");
        check("r250_count", {20'd0, sec_count}, 32'd250);
        check("r250_low",   {31'd0, low_time}, 32'd0);
        check("r250_blink", {31'd0, blink}, 32'd0);
        rst = 1'b1;
        pulse(4'b0001, 1'b0);
        rst = 1'b0;
        show("mid_reset");
        check("mrst_count", {20'd0, sec_count}, 32'd0);
        check("mrst_state", {30'd0, state}, 32'd0);
        check("mrst_blink", {31'd0, blink}, 32'd0);
        step();
        step();
        step();
        check("mrst_first_tick", {31'd0, tick}, 32'd1);

        // 6: ticks while EMPTY, then the low-time threshold boundary
        for (int i = 0; i < 3; i++) begin
            run_ticks(1);
            check("empty_count", {20'd0, sec_count}, 32'd0);
            check("empty_state", {30'd0, state}, 32'd0);
            check("empty_blink", {31'd0, blink}, 32'd0);
        end
        run_to_phase(0);
        pulse(4'b0100, 1'b0);
        show("thresh180");
        check("t180_count", {20'd0, sec_count}, 32'd180);
        check("t180_low",   {31'd0, low_time}, 32'd1);
        pulse(4'b0001, 1'b0);
        show("thresh240");
        check("t240_count", {20'd0, sec_count}, 32'd240);
        check("t240_low",   {31'd0, low_time}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
